lidar_packet_parser: RTL and testbench

//  Parses the byte stream from the PMOD UART receiver into single-pixel frame-buffer writes.

---
 rtl/lidar_packet_parser.sv | 146 ++++++++++++++
 tb/tb_lidar_packet_parser.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lidar_packet_parser.sv
// Turns the UART byte stream into single-pixel frame-buffer writes.
// Checks framing, checksum and coordinate range, and aborts a packet after an inter-byte timeout.
//
// state | meaning
// IDLE  | waiting for the sync byte
// XLO   | expecting X low byte
// XHI   | expecting X high byte
// YLO   | expecting Y low byte
// YHI   | expecting Y high byte
// PIX   | expecting pixel byte
// CSUM  | expecting checksum; accept or reject, then back to IDLE
module lidar_packet_parser #(
  parameter int          WIDTH          = 360,
  parameter int          HEIGHT         = 360,
  parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
  parameter int          TIMEOUT_CYCLES = 7425
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic        valid_pixel_out,
  output logic        pixel_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic [2:0]  state_out,
  output logic [15:0] pkt_ok_out,
  output logic [15:0] pkt_err_out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    XLO  = 3'd1,
    XHI  = 3'd2,
    YLO  = 3'd3,
    YHI  = 3'd4,
    PIX  = 3'd5,
    CSUM = 3'd6
  } state_t;

  localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [10:0]     X_LIMIT  = 11'(WIDTH);
  localparam logic [9:0]      Y_LIMIT  = 10'(HEIGHT);

  state_t        state, state_next;
  logic [TW-1:0] tmr;
  logic [7:0]    x_lo, y_lo, csum;
  logic [2:0]    x_hi;
  logic [1:0]    y_hi;
  logic          pix;
  logic [10:0]   x_pos;
  logic [9:0]    y_pos;
  logic          expired, pkt_good, accept, reject;

  assign x_pos     = {x_hi, x_lo};
  assign y_pos     = {y_hi, y_lo};
  assign pkt_good  = (data_in == csum) && (x_pos < X_LIMIT) && (y_pos < Y_LIMIT);
  // A byte arriving on the expiry cycle takes priority over the abort.
  assign expired   = (state != IDLE) && (tmr == '0) && !valid_in;
  assign state_out = state;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    if (expired) begin
      state_next = IDLE;
    end else if (valid_in) begin
      case (state)
        IDLE: if (data_in == SYNC_BYTE) state_next = XLO;
        XLO:  state_next = XHI;
        XHI:  state_next = YLO;
        YLO:  state_next = YHI;
        YHI:  state_next = PIX;
        PIX:  state_next = CSUM;
        CSUM: begin
          state_next = IDLE;
          accept     = pkt_good;
          reject     = !pkt_good;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Down-counter reloaded on every byte; terminal count 0 marks TIMEOUT_CYCLES idle cycles.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                         tmr <= TMR_LOAD;
    else if (state == IDLE || valid_in) tmr <= TMR_LOAD;
    else if (tmr != '0)                 tmr <= tmr - 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      x_lo <= '0;
      x_hi <= '0;
      y_lo <= '0;
      y_hi <= '0;
      pix  <= 1'b0;
      csum <= '0;
    end else begin
      if (state == IDLE)
        csum <= '0;
      else if (valid_in && state != CSUM)
        csum <= csum ^ data_in;
      if (valid_in) begin
        case (state)
          XLO:     x_lo <= data_in;
          XHI:     x_hi <= data_in[2:0];
          YLO:     y_lo <= data_in;
          YHI:     y_hi <= data_in[1:0];
          PIX:     pix  <= data_in[0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_pixel_out <= 1'b0;
      pixel_out       <= 1'b0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      pkt_ok_out      <= '0;
      pkt_err_out     <= '0;
    end else begin
      valid_pixel_out <= accept;
      if (accept) begin
        hcount_out <= x_pos;
        vcount_out <= y_pos;
        pixel_out  <= pix;
        if (pkt_ok_out != 16'hFFFF) pkt_ok_out <= pkt_ok_out + 1'b1;
      end
      if ((reject || expired) && pkt_err_out != 16'hFFFF)
        pkt_err_out <= pkt_err_out + 1'b1;
    end
  end

endmodule

// File: tb/tb_lidar_packet_parser.sv
// Directed bench for lidar_packet_parser: framing, checksum, range, timeout,
// back-to-back traffic and asynchronous reset.
module tb_lidar_packet_parser;

  localparam int TO = 7425;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        valid_pixel_out;
  logic        pixel_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic [2:0]  state_out;
  logic [15:0] pkt_ok_out;
  logic [15:0] pkt_err_out;

  int errors = 0;
  int checks = 0;
  int strobes = 0;
  int s0;

  lidar_packet_parser dut (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .valid_in(valid_in),
    .valid_pixel_out(valid_pixel_out), .pixel_out(pixel_out),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .state_out(state_out),
    .pkt_ok_out(pkt_ok_out), .pkt_err_out(pkt_err_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) if (valid_pixel_out === 1'b1) strobes <= strobes + 1;

  task automatic send(input logic [7:0] b);
    data_in  = b;
    valid_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

  task automatic send7(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
    send(b0); send(b1); send(b2); send(b3); send(b4); send(b5); send(b6);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic apply_reset;
    rst_in = 1'b1; valid_in = 1'b0; data_in = 8'h00;
    idle(2);
    rst_in = 1'b0;
    idle(1);
  endtask

  task automatic test_reset;
    apply_reset();
    checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_out); end
    checks++; if (valid_pixel_out !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %0d want 0", valid_pixel_out); end
    checks++; if (hcount_out !== 11'd0 || vcount_out !== 10'd0 || pixel_out !== 1'b0) begin errors++; $display("FAIL reset_coords: got h=%0d v=%0d p=%0d want 0 0 0", hcount_out, vcount_out, pixel_out); end
    checks++; if (pkt_ok_out !== 16'd0 || pkt_err_out !== 16'd0) begin errors++; $display("FAIL reset_counts: got ok=%0d err=%0d want 0 0", pkt_ok_out, pkt_err_out); end
  endtask

  task automatic test_accept;
    apply_reset();
    s0 = strobes;
    send7(8'hAA, 8'h10, 8'h00, 8'h20, 8'h00, 8'h01, 8'h31);
    checks++; if (valid_pixel_out !== 1'b1) begin errors++; $display("FAIL accept_strobe: got %0d want 1", valid_pixel_out); end
    checks++; if (hcount_out !== 11'd16 || vcount_out !== 10'd32) begin errors++; $display("FAIL accept_coords: got h=%0d v=%0d want 16 32", hcount_out, vcount_out); end
    checks++; if (pixel_out !== 1'b1) begin errors++; $display("FAIL accept_pixel: got %0d want 1", pixel_out); end
    checks++; if (pkt_ok_out !== 16'd1 || pkt_err_out !== 16'd0) begin errors++; $display("FAIL accept_counts: got ok=%0d err=%0d want 1 0", pkt_ok_out, pkt_err_out); end
    checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL accept_state: got %0d want 0", state_out); end
    idle(1);
    checks++; if (valid_pixel_out !== 1'b0) begin errors++; $display("FAIL accept_strobe_width: got %0d want 0", valid_pixel_out); end
    checks++; if (hcount_out !== 11'd16 || vcount_out !== 10'd32 || pixel_out !== 1'b1) begin errors++; $display("FAIL accept_hold: got h=%0d v=%0d p=%0d want 16 32 1", hcount_out, vcount_out, pixel_out); end
    checks++; if (strobes - s0 !== 1) begin errors++; $display("FAIL accept_strobe_count: got %0d want 1", strobes - s0); end
  endtask

  task automatic test_bad_csum;
    apply_reset();
    s0 = strobes;
    send7(8'hAA, 8'h10, 8'h00, 8'h20, 8'h00, 8'h01, 8'h30);
    checks++; if (valid_pixel_out !== 1'b0) begin errors++; $display("FAIL csum_strobe: got %0d want 0", valid_pixel_out); end
    checks++; if (pkt_err_out !== 16'd1 || pkt_ok_out !== 16'd0) begin errors++; $display("FAIL csum_counts: got ok=%0d err=%0d want 0 1", pkt_ok_out, pkt_err_out); end
    checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL csum_state: got %0d want 0", state_out); end
    idle(1);
    checks++; if (strobes - s0 !== 0 || hcount_out !== 11'd0) begin errors++; $display("FAIL csum_no_write: got strobes=%0d h=%0d want 0 0", strobes - s0, hcount_out); end
  endtask

  task automatic test_range;
    apply_reset();
    send7(8'hAA, 8'h68, 8'h01, 8'h00, 8'h00, 8'h01, 8'h68);
    checks++; if (valid_pixel_out !== 1'b0 || pkt_err_out !== 16'd1) begin errors++; $display("FAIL range_x360: got strobe=%0d err=%0d want 0 1", valid_pixel_out, pkt_err_out); end
    send7(8'hAA, 8'h67, 8'h01, 8'h00, 8'h00, 8'h01, 8'h67);
    checks++; if (valid_pixel_out !== 1'b1 || hcount_out !== 11'd359 || pkt_ok_out !== 16'd1) begin errors++; $display("FAIL range_x359: got strobe=%0d h=%0d ok=%0d want 1 359 1", valid_pixel_out, hcount_out, pkt_ok_out); end
    send7(8'hAA, 8'h00, 8'h00, 8'h68, 8'h01, 8'h01, 8'h68);
    checks++; if (valid_pixel_out !== 1'b0 || pkt_err_out !== 16'd2 || hcount_out !== 11'd359) begin errors++; $display("FAIL range_y360: got strobe=%0d err=%0d h=%0d want 0 2 359", valid_pixel_out, pkt_err_out, hcount_out); end
    // high bits of X_HI/Y_HI set but masked off: x=1, y=2
    send7(8'hAA, 8'h01, 8'hF8, 8'h02, 8'hFC, 8'h00, 8'h07);
    checks++; if (valid_pixel_out !== 1'b1 || hcount_out !== 11'd1 || vcount_out !== 10'd2 || pixel_out !== 1'b0) begin errors++; $display("FAIL range_mask: got strobe=%0d h=%0d v=%0d p=%0d want 1 1 2 0", valid_pixel_out, hcount_out, vcount_out, pixel_out); end
    checks++; if (pkt_ok_out !== 16'd2 || pkt_err_out !== 16'd2) begin errors++; $display("FAIL range_counts: got ok=%0d err=%0d want 2 2", pkt_ok_out, pkt_err_out); end
  endtask

  task automatic test_payload_sync;
    apply_reset();
    send7(8'hAA, 8'hAA, 8'h00, 8'hAA, 8'h00, 8'h01, 8'h01);
    checks++; if (valid_pixel_out !== 1'b1 || hcount_out !== 11'd170 || vcount_out !== 10'd170) begin errors++; $display("FAIL payload_sync: got strobe=%0d h=%0d v=%0d want 1 170 170", valid_pixel_out, hcount_out, vcount_out); end
  endtask

  task automatic test_timeout;
    apply_reset();
    send(8'hAA); send(8'h05);
    checks++; if (state_out !== 3'd2) begin errors++; $display("FAIL timeout_pre_state: got %0d want 2", state_out); end
    idle(TO - 1);
    checks++; if (state_out !== 3'd2 || pkt_err_out !== 16'd0) begin errors++; $display("FAIL timeout_early: got state=%0d err=%0d want 2 0", state_out, pkt_err_out); end
    idle(1);
    checks++; if (state_out !== 3'd0 || pkt_err_out !== 16'd1) begin errors++; $display("FAIL timeout_expire: got state=%0d err=%0d want 0 1", state_out, pkt_err_out); end
    send(8'hAA);
    idle(TO - 1);
    send(8'h05);
    checks++; if (state_out !== 3'd2 || pkt_err_out !== 16'd1) begin errors++; $display("FAIL timeout_byte_wins: got state=%0d err=%0d want 2 1", state_out, pkt_err_out); end
  endtask

  task automatic test_garbage;
    apply_reset();
    s0 = strobes;
    send(8'h00); send(8'hFF); send(8'h12);
    send7(8'hAA, 8'h2C, 8'h01, 8'h64, 8'h00, 8'h00, 8'h49);
    checks++; if (valid_pixel_out !== 1'b1 || hcount_out !== 11'd300 || vcount_out !== 10'd100 || pixel_out !== 1'b0) begin errors++; $display("FAIL garbage_pkt: got strobe=%0d h=%0d v=%0d p=%0d want 1 300 100 0", valid_pixel_out, hcount_out, vcount_out, pixel_out); end
    idle(1);
    checks++; if (pkt_err_out !== 16'd0 || pkt_ok_out !== 16'd1 || strobes - s0 !== 1) begin errors++; $display("FAIL garbage_counts: got err=%0d ok=%0d strobes=%0d want 0 1 1", pkt_err_out, pkt_ok_out, strobes - s0); end
  endtask

  task automatic test_back_to_back;
    apply_reset();
    s0 = strobes;
    send7(8'hAA, 8'h10, 8'h00, 8'h20, 8'h00, 8'h01, 8'h31);
    checks++; if (valid_pixel_out !== 1'b1 || hcount_out !== 11'd16) begin errors++; $display("FAIL b2b_first: got strobe=%0d h=%0d want 1 16", valid_pixel_out, hcount_out); end
    send7(8'hAA, 8'h05, 8'h00, 8'h07, 8'h00, 8'hFF, 8'hFD);
    checks++; if (valid_pixel_out !== 1'b1 || hcount_out !== 11'd5 || vcount_out !== 10'd7 || pixel_out !== 1'b1) begin errors++; $display("FAIL b2b_second: got strobe=%0d h=%0d v=%0d p=%0d want 1 5 7 1", valid_pixel_out, hcount_out, vcount_out, pixel_out); end
    idle(1);
    checks++; if (pkt_ok_out !== 16'd2 || strobes - s0 !== 2) begin errors++; $display("FAIL b2b_counts: got ok=%0d strobes=%0d want 2 2", pkt_ok_out, strobes - s0); end
  endtask

  task automatic test_async_reset;
    apply_reset();
    s0 = strobes;
    send7(8'hAA, 8'h10, 8'h00, 8'h20, 8'h00, 8'h01, 8'h31);
    send(8'hAA); send(8'h10); send(8'h00);
    checks++; if (state_out !== 3'd3 || pkt_ok_out !== 16'd1) begin errors++; $display("FAIL async_pre: got state=%0d ok=%0d want 3 1", state_out, pkt_ok_out); end
    #2 rst_in = 1'b1;
    #1;
    checks++; if (state_out !== 3'd0 || pkt_ok_out !== 16'd0 || pkt_err_out !== 16'd0) begin errors++; $display("FAIL async_state: got state=%0d ok=%0d err=%0d want 0 0 0", state_out, pkt_ok_out, pkt_err_out); end
    checks++; if (hcount_out !== 11'd0 || vcount_out !== 10'd0 || pixel_out !== 1'b0 || valid_pixel_out !== 1'b0) begin errors++; $display("FAIL async_outputs: got h=%0d v=%0d p=%0d s=%0d want 0 0 0 0", hcount_out, vcount_out, pixel_out, valid_pixel_out); end
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    send(8'h20); send(8'h00); send(8'h01); send(8'h31);
    idle(2);
    checks++; if (strobes - s0 !== 1 || pkt_ok_out !== 16'd0 || state_out !== 3'd0) begin errors++; $display("FAIL async_tail: got strobes=%0d ok=%0d state=%0d want 1 0 0", strobes - s0, pkt_ok_out, state_out); end
  endtask

  initial begin
    rst_in = 1'b1; valid_in = 1'b0; data_in = 8'h00;
    test_reset();
    test_accept();
    test_bad_csum();
    test_range();
    test_payload_sync();
    test_timeout();
    test_garbage();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
